// File: rtl/gray_arb_pkg.sv
// Shared types and helpers for the round-robin gray decode arbiter.
// The winner search is written once here so the top stays a plain datapath.
package gray_arb_pkg;

    localparam int GRAY_W  = 4;
    localparam int MAX_REQ = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // First set bit of req searching ptr, ptr+1, ... wrapping at num_req; 0 if none.
    function automatic int rr_winner(input logic [MAX_REQ-1:0] req, input int ptr,
                                     input int num_req);
        int   idx;
        int   win;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= num_req) idx = idx - num_req;
            if (i < num_req && !found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// 4-bit combinational gray-to-binary converter.
// Each binary bit is the gray bit XORed with the next-higher binary bit.
module gray_to_binary (
    input  logic [3:0] gray,
    output logic [3:0] binary
);

    assign binary[3] = gray[3];
    assign binary[2] = gray[2] ^ binary[3];
    assign binary[1] = gray[1] ^ binary[2];
    assign binary[0] = gray[0] ^ binary[1];

endmodule

// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter sharing one gray_to_binary converter among NUM_REQ sources,
// with a single registered valid/ready output slot tagged by requester index.
//
//   state      | meaning
//   SLOT_EMPTY | no result held, out_valid=0, next request is granted at once
//   SLOT_FULL  | result held on out_binary/out_id until out_ready pops it
module gray_decode_arbiter
    import gray_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [GRAY_W*NUM_REQ-1:0] req_gray,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [GRAY_W-1:0]         out_binary,
    output logic [ID_W-1:0]           out_id,
    output logic                      busy
);

    slot_state_t       slot_state_q;
    slot_state_t       slot_state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   win_id;
    logic [GRAY_W-1:0] gray_sel;
    logic [GRAY_W-1:0] bin_sel;
    logic              slot_free;
    logic              grant_fire;

    assign win_id     = ID_W'(rr_winner(MAX_REQ'(req), int'(ptr_q), NUM_REQ));
    assign slot_free  = (slot_state_q == SLOT_EMPTY) || out_ready;
    assign grant_fire = !rst && slot_free && (|req);

    always_comb begin
        gray_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_id) gray_sel = req_gray[i*GRAY_W +: GRAY_W];
        end
    end

    gray_to_binary u_gray_to_binary (
        .gray   (gray_sel),
        .binary (bin_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_state_q <= SLOT_EMPTY;
            ptr_q        <= '0;
            out_binary   <= '0;
            out_id       <= '0;
        end else begin
            slot_state_q <= slot_state_d;
            if (grant_fire) begin
                out_binary <= bin_sel;
                out_id     <= win_id;
                ptr_q      <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
            end
        end
    end

    always_comb begin
        slot_state_d = slot_state_q;
        if (grant_fire) begin
            slot_state_d = SLOT_FULL;
        end else if (slot_state_q == SLOT_FULL && out_ready) begin
            slot_state_d = SLOT_EMPTY;
        end
    end

    always_comb begin
        gnt = '0;
        if (grant_fire) gnt[win_id] = 1'b1;
        out_valid = (slot_state_q == SLOT_FULL);
        busy      = out_valid;
    end

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed bench for gray_decode_arbiter with NUM_REQ=4.
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
module tb_gray_decode_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_gray;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_binary;
    logic [1:0]  out_id;
    logic        busy;

    int checks;
    int errors;

    gray_decode_arbiter #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_gray   (req_gray),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_binary (out_binary),
        .out_id     (out_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        req_gray  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b expected 0", out_valid);
        end
        checks++;
        if (out_binary !== 4'b0000 || out_id !== 2'd0) begin
            errors++; $display("FAIL reset_data got %b/%0d expected 0000/0", out_binary, out_id);
        end
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_busy_gnt got %b/%b expected 0/0000", busy, gnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; req_gray[3:0] = 4'b1011; out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL single_gnt got %b expected 0001", gnt);
        end
        tick();
        req = 4'b0000;
        checks++;
        if (out_valid !== 1'b1 || out_binary !== 4'b1101 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL single_out got v%b %b id%0d expected v1 1101 id0", out_valid, out_binary, out_id);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL single_busy got %b expected 1", busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_binary !== 4'b1101 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL single_pop got v%b %b id%0d expected v0 1101 id0", out_valid, out_binary, out_id);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5];
        logic [3:0] exp_bin [5];
        logic [1:0] exp_id  [5];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_bin = '{4'b0000, 4'b1111, 4'b0100, 4'b1101, 4'b0000};
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111; req_gray = {4'b1011, 4'b0110, 4'b1000, 4'b0000}; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (gnt !== exp_gnt[k]) begin
                errors++; $display("FAIL rr_gnt[%0d] got %b expected %b", k, gnt, exp_gnt[k]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_binary !== exp_bin[k] || out_id !== exp_id[k]) begin
                errors++;
                $display("FAIL rr_out[%0d] got v%b %b id%0d expected v1 %b id%0d",
                         k, out_valid, out_binary, out_id, exp_bin[k], exp_id[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0110; req_gray = {4'b0000, 4'b0101, 4'b0010, 4'b0000}; out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_binary !== 4'b0011 || out_id !== 2'd1) begin
            errors++;
            $display("FAIL bp_first got v%b %b id%0d expected v1 0011 id1", out_valid, out_binary, out_id);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (gnt !== 4'b0000) begin
                errors++; $display("FAIL bp_gnt[%0d] got %b expected 0000", k, gnt);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_binary !== 4'b0011 || out_id !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v%b %b id%0d expected v1 0011 id1", k, out_valid, out_binary, out_id);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++; $display("FAIL bp_release_gnt got %b expected 0100", gnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_binary !== 4'b0110 || out_id !== 2'd2) begin
            errors++;
            $display("FAIL bp_reload got v%b %b id%0d expected v1 0110 id2", out_valid, out_binary, out_id);
        end
    endtask

    task automatic test_ptr_skip();
        do_reset();
        req_gray = {4'b0000, 4'b0000, 4'b0001, 4'b0011}; out_ready = 1'b1;
        req = 4'b0010;
        tick();
        req = 4'b0011;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL skip_wrap_gnt got %b expected 0001", gnt);
        end
        tick();
        checks++;
        if (out_id !== 2'd0 || out_binary !== 4'b0010) begin
            errors++; $display("FAIL skip_wrap_out got %b id%0d expected 0010 id0", out_binary, out_id);
        end
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL skip_next_ptr got %b expected 0010", gnt);
        end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111; req_gray = {4'b0001, 4'b0001, 4'b0001, 4'b0001}; out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) begin
            errors++; $display("FAIL mid_setup got v%b id%0d expected v1 id0", out_valid, out_id);
        end
        rst = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_gnt got %b expected 0000", gnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++; $display("FAIL mid_after_rst got v%b gnt %b expected v0 0000", out_valid, gnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL mid_restart_gnt got %b expected 0001", gnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_binary !== 4'b0001) begin
            errors++;
            $display("FAIL mid_restart_out got v%b %b id%0d expected v1 0001 id0", out_valid, out_binary, out_id);
        end
    endtask

    task automatic test_exhaustive_decode();
        logic [3:0] exp_bin [16];
        exp_bin = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                    4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        for (int g = 0; g < 16; g++) begin
            req_gray[3:0] = 4'(g);
            #1;
            checks++;
            if (gnt !== 4'b0001) begin
                errors++; $display("FAIL dec_gnt[%0d] got %b expected 0001", g, gnt);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_binary !== exp_bin[g] || out_id !== 2'd0) begin
                errors++;
                $display("FAIL dec_out[%0d] got v%b %b id%0d expected v1 %b id0",
                         g, out_valid, out_binary, out_id, exp_bin[g]);
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req       = '0;
        req_gray  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_ptr_skip();
        test_reset_mid();
        test_exhaustive_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
